// File: rtl/syn_io_client_if.sv
// Bundle between the core, syn_io_client and the synapse I/O responder.
// master = client side, slave = core/responder side.
interface syn_io_client_if #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned PAT_CTR_W = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 start;
    logic                 busy;
    logic                 syn2client_valid;
    logic                 syn2client_channel;
    logic [DATA_W-1:0]    syn2client_data;
    logic [PAT_CTR_W-1:0] syn2client_pat_ctr;
    logic                 result_valid;
    logic                 result_ready;
    logic [DATA_W-1:0]    result_data0;
    logic [DATA_W-1:0]    result_data1;
    logic [PAT_CTR_W-1:0] result_pat_ctr;
    logic                 result_error;

    modport master (
        input  cmd_valid, busy, syn2client_valid, syn2client_channel, syn2client_data,
               syn2client_pat_ctr, result_ready,
        output cmd_ready, start, result_valid, result_data0, result_data1, result_pat_ctr,
               result_error
    );

    modport slave (
        output cmd_valid, busy, syn2client_valid, syn2client_channel, syn2client_data,
               syn2client_pat_ctr, result_ready,
        input  cmd_ready, start, result_valid, result_data0, result_data1, result_pat_ctr,
               result_error
    );
endinterface

// File: rtl/syn_io_client.sv
// Core-side initiator: issues start, gathers two result beats, returns them via valid/ready.
// Define SYN_IO_CLIENT_TIMEOUT_EN to force completion after TIMEOUT_CYCLES in START+WAIT.
module syn_io_client #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned PAT_CTR_W = 8
`ifdef SYN_IO_CLIENT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input logic             clk,
    input logic             reset,
    syn_io_client_if.master bus
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 start_q, start_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 got0_q, got0_d;
    logic                 got1_q, got1_d;
    logic [DATA_W-1:0]    data0_q, data0_d;
    logic [DATA_W-1:0]    data1_q, data1_d;
    logic [PAT_CTR_W-1:0] pat_q, pat_d;
    logic                 accept, beat0, beat1, got0_n, got1_n, complete, timeout;

    assign accept = (state_q == StIdle) && cmd_ready_q && bus.cmd_valid;
    assign beat0  = (state_q == StWait) && bus.syn2client_valid && !bus.syn2client_channel;
    assign beat1  = (state_q == StWait) && bus.syn2client_valid && bus.syn2client_channel;
    // A beat landing with the fall of busy counts toward this cycle's completion.
    assign got0_n   = got0_q | beat0;
    assign got1_n   = got1_q | beat1;
    assign complete = (state_q == StWait) && got0_n && got1_n && !bus.busy;

`ifdef SYN_IO_CLIENT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == StStart || state_q == StWait) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (complete || timeout) state_d = StDone;
            StDone:  if (bus.result_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        pat_d   = pat_q;
        err_d   = err_q;
        got0_d  = got0_q;
        got1_d  = got1_q;
        if (accept) begin
            data0_d = '0;
            data1_d = '0;
            err_d   = 1'b0;
            got0_d  = 1'b0;
            got1_d  = 1'b0;
        end
        if (beat0) begin
            data0_d = bus.syn2client_data;
            pat_d   = bus.syn2client_pat_ctr;
            got0_d  = 1'b1;
            if (got0_q) err_d = 1'b1;
        end
        if (beat1) begin
            data1_d = bus.syn2client_data;
            pat_d   = bus.syn2client_pat_ctr;
            got1_d  = 1'b1;
            if (got1_q) err_d = 1'b1;
        end
        if (timeout && !complete) err_d = 1'b1;
        // Flags are registered from the next state so every output comes straight off a flop.
        cmd_ready_d = (state_d == StIdle);
        start_d     = (state_d == StStart);
        valid_d     = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready_q <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            got0_q      <= 1'b0;
            got1_q      <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            pat_q       <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            got0_q      <= got0_d;
            got1_q      <= got1_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            pat_q       <= pat_d;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.start          = start_q;
    assign bus.result_valid   = valid_q;
    assign bus.result_error   = err_q;
    assign bus.result_data0   = data0_q;
    assign bus.result_data1   = data1_q;
    assign bus.result_pat_ctr = pat_q;

endmodule

// File: tb/tb_syn_io_client.sv
// Bench for syn_io_client: directed vector table, reset/timeout sequences, randomized
// transactions scored against a per-channel beat-count model.
`timescale 1ns/1ps
module tb_syn_io_client;
    localparam int unsigned DW = 128;
    localparam int unsigned PW = 8;
    localparam logic [DW-1:0] WA = {4{32'haffe_affe}};
    localparam logic [DW-1:0] WB = {4{32'habcd_0123}};

    typedef struct {
        string              name;
        logic [2:0]         bv;
        logic [2:0]         bch;
        logic [2:0][DW-1:0] bd;
        logic [2:0][PW-1:0] bp;
        int                 busy_cyc;
        int                 hold;
        logic [DW-1:0]      exp_d0;
        logic [DW-1:0]      exp_d1;
        logic [PW-1:0]      exp_pat;
        logic               exp_err;
        int                 exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    syn_io_client_if #(.DATA_W(DW), .PAT_CTR_W(PW)) bus ();

    syn_io_client #(
        .DATA_W(DW),
        .PAT_CTR_W(PW)
`ifdef SYN_IO_CLIENT_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic v, input logic ch, input logic [DW-1:0] d,
                              input logic [PW-1:0] p);
        bus.syn2client_valid   = v;
        bus.syn2client_channel = ch;
        bus.syn2client_data    = d;
        bus.syn2client_pat_ctr = p;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
        check("cmd_ready_wait", bus.cmd_ready, 1);
    endtask

    // Accept a command; afterwards the START cycle is visible.
    task automatic issue_cmd(input string tag);
        wait_ready();
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        check({tag, "_start_hi"}, {bus.start, bus.cmd_ready}, 2'b10);
    endtask

    task automatic hold_and_consume(input string tag, input int hold, input logic [DW-1:0] d0,
                                    input logic [DW-1:0] d1, input logic err);
        for (int i = 0; i < hold; i++) begin
            bus.result_ready = 1'b0;
            bus.cmd_valid    = 1'b1;
            drive_beat(1'b1, 1'($urandom), {4{$urandom}}, 8'($urandom));
            tick();
            check({tag, "_hold_ctl"}, {bus.result_valid, bus.cmd_ready, bus.start}, 3'b100);
            check({tag, "_hold_data"}, bus.result_data0 ^ bus.result_data1, d0 ^ d1);
            check({tag, "_hold_err"}, bus.result_error, err);
        end
        bus.cmd_valid    = 1'b0;
        bus.result_ready = 1'b1;
        drive_beat(1'b0, 1'b0, '0, '0);
        tick();
        bus.result_ready = 1'b0;
        check({tag, "_consumed"}, {bus.result_valid, bus.cmd_ready}, 2'b01);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        logic seen;
        issue_cmd(v.name);
        drive_beat(1'b1, 1'b1, 128'hbad, 8'hee);
        bus.busy = (v.busy_cyc > 0);
        tick();
        check({v.name, "_start_lo"}, bus.start, 0);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (i < 3 && v.bv[i]) drive_beat(1'b1, v.bch[i], v.bd[i], v.bp[i]);
            else drive_beat(1'b0, 1'($urandom), {4{$urandom}}, 8'($urandom));
            bus.busy = (i < v.busy_cyc);
            tick();
            lat++;
            if (bus.result_valid) seen = 1'b1;
        end
        drive_beat(1'b0, 1'b0, '0, '0);
        bus.busy = 1'b0;
        check({v.name, "_lat"}, lat, v.exp_lat);
        check({v.name, "_d0"}, bus.result_data0, v.exp_d0);
        check({v.name, "_d1"}, bus.result_data1, v.exp_d1);
        check({v.name, "_pat"}, bus.result_pat_ctr, v.exp_pat);
        check({v.name, "_err"}, bus.result_error, v.exp_err);
        hold_and_consume(v.name, v.hold, v.exp_d0, v.exp_d1, v.exp_err);
    endtask

    // Model: per-channel last word and beat count; done once both seen and busy low.
    task automatic run_rand(input int idx);
        logic [DW-1:0] w [2];
        int            c [2];
        logic [PW-1:0] pl;
        logic          err, done, v, ch, bz;
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        w[0] = '0; w[1] = '0; c[0] = 0; c[1] = 0; pl = '0; err = 1'b0; done = 1'b0;
        issue_cmd("rnd");
        drive_beat(1'($urandom), 1'($urandom), {4{$urandom}}, 8'($urandom));
        bus.busy = 1'($urandom);
        tick();
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            p = 8'($urandom);
            if (cyc >= 8) begin
                bz = 1'b0;
                v  = (c[0] == 0 || c[1] == 0) ? 1'b1 : 1'($urandom);
                ch = (c[0] == 0) ? 1'b0 : (c[1] == 0) ? 1'b1 : 1'($urandom);
            end else begin
                bz = 1'($urandom);
                v  = 1'($urandom);
                ch = 1'($urandom);
            end
            drive_beat(v, ch, d, p);
            bus.busy = bz;
            if (v) begin
                w[ch] = d;
                if (c[ch] > 0) err = 1'b1;
                c[ch]++;
                pl = p;
            end
            done = (c[0] > 0) && (c[1] > 0) && !bz;
            tick();
            check("rnd_valid", {bus.start, bus.result_valid}, {1'b0, done});
        end
        drive_beat(1'b0, 1'b0, '0, '0);
        bus.busy = 1'b0;
        check("rnd_d0", bus.result_data0, w[0]);
        check("rnd_d1", bus.result_data1, w[1]);
        check("rnd_pat", bus.result_pat_ctr, pl);
        check("rnd_err", bus.result_error, err);
        hold_and_consume("rnd", idx % 4, w[0], w[1], err);
    endtask

    initial begin
        int   t;
        logic seen;
        vecs[0] = '{name:"min", bv:3'b011, bch:3'b010, bd:{{DW{1'b0}}, WB, WA},
                    bp:{8'h00, 8'h12, 8'h11}, busy_cyc:0, hold:2, exp_d0:WA, exp_d1:WB,
                    exp_pat:8'h12, exp_err:1'b0, exp_lat:2};
        vecs[1] = '{name:"nominal", bv:3'b011, bch:3'b010, bd:{{DW{1'b0}}, WB, WA},
                    bp:{8'h00, 8'h22, 8'h21}, busy_cyc:10, hold:20, exp_d0:WA, exp_d1:WB,
                    exp_pat:8'h22, exp_err:1'b0, exp_lat:11};
        vecs[2] = '{name:"ooo", bv:3'b101, bch:3'b001, bd:{WA, {DW{1'b0}}, WB},
                    bp:{8'h33, 8'h00, 8'h31}, busy_cyc:2, hold:1, exp_d0:WA, exp_d1:WB,
                    exp_pat:8'h33, exp_err:1'b0, exp_lat:3};
        vecs[3] = '{name:"dup", bv:3'b111, bch:3'b100, bd:{WB, 128'h1, WA},
                    bp:{8'h44, 8'h43, 8'h42}, busy_cyc:0, hold:3, exp_d0:128'h1, exp_d1:WB,
                    exp_pat:8'h44, exp_err:1'b1, exp_lat:3};

        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.busy = 1'b0;
        bus.result_ready = 1'b0;
        drive_beat(1'b0, 1'b0, '0, '0);
        tick();
        check("rst_ctl", {bus.cmd_ready, bus.start, bus.result_valid, bus.result_error}, 4'b0);
        check("rst_d0", bus.result_data0, 0);
        check("rst_d1", bus.result_data1, 0);
        check("rst_pat", bus.result_pat_ctr, 0);
        tick();
        check("rst_ready_held", bus.cmd_ready, 0);
        reset = 1'b0;
        tick();
        check("rst_ready_after", bus.cmd_ready, 1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Beat while idle must not disturb the held result.
        drive_beat(1'b1, 1'b0, 128'h77, 8'h77);
        tick();
        drive_beat(1'b0, 1'b0, '0, '0);
        tick();
        check("idle_beat_d0", bus.result_data0, 128'h1);
        check("idle_beat_pat", bus.result_pat_ctr, 8'h44);
        check("idle_beat_err", bus.result_error, 1);

        // Reset mid-WAIT after the ch0 beat.
        issue_cmd("midrst");
        bus.busy = 1'b1;
        tick();
        drive_beat(1'b1, 1'b0, WA, 8'h05);
        tick();
        check("midrst_cap", bus.result_data0, WA);
        drive_beat(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.busy = 1'b0;
        check("midrst_ctl", {bus.cmd_ready, bus.start, bus.result_valid, bus.result_error}, 4'b0);
        check("midrst_d0", bus.result_data0, 0);
        check("midrst_pat", bus.result_pat_ctr, 0);
        drive_beat(1'b1, 1'b1, WB, 8'h06);
        tick();
        drive_beat(1'b0, 1'b0, '0, '0);
        check("midrst_ch1_ign", bus.result_data1, 0);
        check("midrst_ready", {bus.cmd_ready, bus.start, bus.result_valid}, 3'b100);
        run_vec(vecs[1]);

        // Silent responder.
        issue_cmd("silent");
        bus.busy = 1'b1;
        t    = 1;
        seen = 1'b0;
`ifdef SYN_IO_CLIENT_TIMEOUT_EN
        while (!bus.result_valid && t < 40) begin
            tick();
            if (!bus.result_valid) t++;
        end
        check("tmo_cycles", t, 16);
        check("tmo_err", bus.result_error, 1);
        check("tmo_d0", bus.result_data0, 0);
        check("tmo_d1", bus.result_data1, 0);
        bus.busy = 1'b0;
        hold_and_consume("tmo", 1, '0, '0, 1'b1);
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.result_valid) seen = 1'b1;
        end
        check("no_tmo", seen, 0);
        check("no_tmo_start", bus.start, 0);
        bus.busy = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
`endif

        for (int i = 0; i < 40; i++) run_rand(i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/syn_io_client.md
# syn_io_client

Processor-side initiator for the synapse I/O interface.
- Accepts a read command from the core and issues a single-cycle `start` to the synapse I/O responder.
- Collects the two 128-bit result beats (channel 0, then channel 1) and the pattern counter.
- Presents them to the core through a valid/ready result port.
- Sits between the core's I/O decode logic and the `Syn_io_if` responder.

## Interface
Parameters:
- `DATA_W`, 128, width of `syn2client_data` and each result word
- `PAT_CTR_W`, 8, width of `syn2client_pat_ctr`
- `TIMEOUT_CYCLES`, 1024, cycles from `start` to forced completion (timeout build only)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `cmd_valid` in 1: core requests a transaction
- `cmd_ready` out 1: block can accept a command (high only in IDLE)
- `start` out 1: to responder, one-cycle pulse
- `busy` in 1: from responder
- `syn2client_valid` in 1: result beat present
- `syn2client_channel` in 1: beat index, 0 or 1
- `syn2client_data` in `DATA_W`: beat payload
- `syn2client_pat_ctr` in `PAT_CTR_W`: pattern counter, sampled with each beat
- `result_valid` out 1: result available
- `result_ready` in 1: core consumes result
- `result_data0` out `DATA_W`: channel 0 word
- `result_data1` out `DATA_W`: channel 1 word
- `result_pat_ctr` out `PAT_CTR_W`: pat_ctr of the last captured beat
- `result_error` out 1: missing, duplicate or timed-out beat

## Operation
State machine states: IDLE, START, WAIT, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, clear capture flags `got0`/`got1`, `result_error` and `result_data0/1`, then go to START.
- START:
  - `start`=1 for exactly this cycle; go to WAIT.
- WAIT: on each `syn2client_valid`, capture `syn2client_data` into the word selected by `syn2client_channel`, capture `syn2client_pat_ctr`, and set the flag for that channel.
  - Beat on an already-set channel: data overwritten, `result_error` set.
  - Completion: `got0 && got1 && !busy` at an edge → DONE.
  - A beat and the fall of `busy` in the same cycle count together: the beat is captured, then completion is evaluated on the updated flags.
  - `busy` low with a flag missing: stay in WAIT.
- DONE:
  - `result_valid`=1; outputs held stable.
  - On `result_ready` → IDLE.
- Beats arriving in IDLE, START or DONE are ignored: no capture, no error.
- `start` is never asserted outside START.
- `cmd_valid` is ignored outside IDLE.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 the cycle after; `start`=0, `result_valid`=0, `result_error`=0, `result_data0`=`result_data1`=0, `result_pat_ctr`=0; state IDLE; timeout counter 0.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No `start` is re-issued, and a beat arriving in the cycle after reset is ignored.
- Command handshake:
  - Command accepted at edge N (`cmd_valid && cmd_ready`).
  - `start` is high in cycle N+1 and low from N+2.
- Completion:
  - Completion condition true at edge M → `result_valid` high from cycle M+1.
  - Result consumed at the first edge with `result_valid && result_ready`; `cmd_ready` is high the following cycle.
- Minimum turnaround is 4 cycles from command acceptance to `result_valid`, with both beats arriving back-to-back immediately after START and `busy` already low.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
Macro `SYN_IO_CLIENT_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(`TIMEOUT_CYCLES`)+1 starts at 0 in START and increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES - 1` while still in WAIT, the block goes to DONE with `result_error`=1; words not received stay 0.
  - Completion and timeout in the same cycle: normal completion wins and `result_error` keeps its prior value.
- Undefined: no counter; WAIT lasts until completion, indefinitely if needed.

## Test plan
- Nominal:
  - Stimulus: command, then a responder model asserting `busy` for 10 cycles and emitting ch0 = {4{32'haffe_affe}}, ch1 = {4{32'habcd_0123}}, then dropping `busy`.
  - Required: `start` high for exactly 1 cycle; `result_valid` 1 cycle after `busy` falls; data words match; `result_error`=0.
- Backpressure:
  - Stimulus: hold `result_ready`=0 for 20 cycles while toggling beat inputs and `cmd_valid`.
  - Required: outputs stable, `cmd_ready`=0, no second `start`; IDLE is reached 1 cycle after `result_ready`.
- Duplicate and stray beats:
  - Stimulus: ch0 beat sent twice (second = 128'h1), then ch1; also a beat while in IDLE.
  - Required: `result_data0`=128'h1, `result_error`=1; the IDLE beat is ignored.
- Out-of-order:
  - Stimulus: ch1 arrives before ch0, and `busy` falls in the same cycle as the ch0 beat.
  - Required: both captured correctly; `result_valid` in the next cycle.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16):
  - Stimulus: responder never answers.
  - Required: `result_valid` with `result_error`=1 and both words 0 after 16 cycles in START+WAIT.
  - Without the macro: no `result_valid` within 1000 cycles.
- Reset mid-WAIT:
  - Stimulus: assert `reset` after the ch0 beat, then send a ch1 beat.
  - Required: all outputs at reset values; the ch1 beat is ignored; the next command completes normally.
